adder_tree_acc: RTL and testbench
=================================

# adder_tree_acc

Accumulation stage directly downstream of the registered adder-tree output. It sums a configurable number of consecutive signed adder-tree partial results (input-channel or kernel-position passes) into one wide output activation. The finished sum is presented on a valid/ready handshake to the next stage. Upstream is throttled via `o_ready` while a finished result waits.

## Interface
- `RW`, `` `NRESULT+1 ``, width of the incoming adder-tree result (signed two's complement)
- `AW`, `RW+8`, accumulator/output width (signed)
- `NW`, 8, width of pass-count input
- `CLK` in 1: single clock, all state on rising edge
- `RST` in 1: reset, synchronous, active-high
- `i_npass` in NW: number of passes per group; sampled on the first beat of a group; 0 treated as 1
- `i_valid` in 1: `i_r` carries a valid partial result
- `i_r` in RW: adder-tree partial result (signed)
- `o_ready` out 1: block accepts a beat this cycle
- `o_valid` out 1: `o_acc` holds a finished group sum
- `i_ready` in 1: downstream consumes `o_acc`
- `o_acc` out AW: accumulated sum (signed)
- `o_sat` out 1: saturation occurred in this group (macro only; else constant 0)

## Operation
- Beat accepted when `i_valid && o_ready`. `i_r` is sign-extended to AW.
- FSM states:
  - IDLE: waiting for first beat.
  - ACC: group in progress.
  - HOLD: result valid, waiting for consumer.
- IDLE, beat accepted:
  - acc ← ext(`i_r`), cnt ← 1, npass_q ← max(`i_npass`,1).
  - Go to HOLD if npass_q==1, else ACC.
- ACC, beat accepted:
  - acc ← acc + ext(`i_r`), cnt ← cnt+1.
  - If cnt+1 == npass_q, go to HOLD.
  - No beat: hold all state.
- HOLD:
  - `o_valid`=1, `o_acc`=acc.
  - `o_ready` = `i_ready`; beats arriving with `i_ready`=0 are not accepted.
  - `i_ready`=1 without beat: go to IDLE.
  - `i_ready`=1 with beat (simultaneous): output consumed and the beat starts a new group exactly as from IDLE, with no bubble.
- `o_ready` = 1 in IDLE/ACC, `i_ready` in HOLD, forced 0 while `RST`=1.
- Arithmetic: two's complement, AW bits. Overflow handling per Configuration.
- `o_acc` stays stable while `o_valid`=1 and `i_ready`=0.

## Timing
- Reset values:
  - state=IDLE, acc=0, cnt=0, npass_q=1.
  - `o_valid`=0, `o_acc`=0, `o_sat`=0, `o_ready`=0 during the reset cycle.
- `RST` mid-group or in HOLD: partial sum and pending result are discarded. First beat is accepted the cycle after `RST` deasserts.
- Latency: `o_valid` rises the cycle after the last beat of a group is accepted.
- Throughput: npass=1 with `i_ready` tied 1 gives one result per cycle. npass=N gives one result per N accepted beats.
- `i_npass` changes mid-group are ignored until the next group's first beat.

## Configuration
- `ADDER_ACC_SATURATE_EN` defined:
  - Each add clamps to [−2^(AW−1), 2^(AW−1)−1].
  - `o_sat` is set sticky on any clamp in the group, and also if the first beat's extension overflows AW (only when AW<RW).
  - `o_sat` clears on the first beat of the next group and on reset.
- Undefined: sums wrap modulo 2^AW and `o_sat` is tied 0.

## Structure
- Shared constants live in `Parameter.v`: `` `NRESULT ``, default accumulator guard bits (8), FSM state encodings (IDLE=2'd0, ACC=2'd1, HOLD=2'd2).
- One sub-module: `acc_sat_add`, a combinational AW-bit signed adder with optional clamp and overflow flag output. It is compiled with or without saturation by the same macro.
- The output register is kept inside the block. It is not a separate CDFF instance, because it needs enable/hold behaviour.

## Test plan
- RW=16, AW=24, npass=4, beats −10,−20,−30,−40 back-to-back, `i_ready`=1 → `o_acc`=−100, `o_valid` for exactly one cycle, one cycle after the 4th beat.
- npass=1, beats 5,7,9 on consecutive cycles, `i_ready`=1 → outputs 5,7,9 on consecutive cycles, `o_ready` constantly 1.
- npass=2, result 3 in HOLD with `i_ready`=0 for 3 cycles while `i_valid`=1 with value 99 → `o_acc`=3 stable and `o_ready`=0 for those 3 cycles. When `i_ready`=1, the beat is accepted in that same cycle and starts the next group.
- AW=16, npass=3, beats −20000 ×3:
  - With macro → `o_acc`=−32768, `o_sat`=1.
  - Without macro → `o_acc`=5536, `o_sat`=0.
- npass=4, `RST` pulsed after 2 beats → all outputs 0. A following group of 1,2,3,4 yields 10.
- `i_npass`=0, beat −7 → treated as npass=1, `o_acc`=−7 one cycle later.

Source files
------------

// File: rtl/adder_tree_acc_pkg.sv
// Shared constants and FSM encoding for the adder-tree accumulation stage.
// Optional saturation is selected with the ADDER_ACC_SATURATE_EN macro.
package adder_tree_acc_pkg;

    localparam int NRESULT   = 15;
    localparam int ACC_GUARD = 8;
    localparam int NPASS_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_e;

endpackage

// File: rtl/adder_tree_acc_sat_add.sv
// Combinational AW-bit signed adder with overflow flag; clamps to the signed
// range when ADDER_ACC_SATURATE_EN is defined, otherwise wraps modulo 2^AW.
module acc_sat_add #(
    parameter int AW = 24
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] b,
    output logic signed [AW-1:0] sum,
    output logic                 ovf
);

    logic [AW:0] wide;

    // One extra bit exposes signed overflow as a mismatch of the two top bits.
    always_comb begin
        wide = {a[AW-1], a} + {b[AW-1], b};
        ovf  = wide[AW] ^ wide[AW-1];
        sum  = wide[AW-1:0];
`ifdef ADDER_ACC_SATURATE_EN
        if (ovf) begin
            sum = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/adder_tree_acc.sv
// Sums npass consecutive signed adder-tree results and presents the total on a
// valid/ready handshake. Define ADDER_ACC_SATURATE_EN for clamping and o_sat.
module adder_tree_acc
    import adder_tree_acc_pkg::*;
#(
    parameter int RW = NRESULT + 1,
    parameter int AW = RW + ACC_GUARD,
    parameter int NW = NPASS_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NW-1:0]        i_npass,
    input  logic                 i_valid,
    input  logic signed [RW-1:0] i_r,
    output logic                 o_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic signed [AW-1:0] o_acc,
    output logic                 o_sat
);

    acc_state_e           state;
    logic signed [AW-1:0] acc;
    logic [NW-1:0]        cnt;
    logic [NW-1:0]        npass_q;
    logic [NW-1:0]        npass_eff;
    logic [NW-1:0]        cnt_next;
    logic signed [AW-1:0] ext;
    logic                 ext_ovf;
    logic signed [AW-1:0] add_sum;
    logic                 add_ovf;
    logic                 beat;

    assign o_ready   = RST ? 1'b0 : ((state == ST_HOLD) ? i_ready : 1'b1);
    assign beat      = i_valid && o_ready;
    assign o_valid   = (state == ST_HOLD);
    assign o_acc     = acc;
    assign npass_eff = (i_npass == '0) ? NW'(1) : i_npass;
    assign cnt_next  = cnt + NW'(1);

    // A narrower accumulator than the input needs a range check on the first beat.
    generate
        if (AW >= RW) begin : g_ext_wide
            assign ext     = AW'(i_r);
            assign ext_ovf = 1'b0;
        end else begin : g_ext_narrow
            logic [RW-AW:0] hi;
            assign hi      = i_r[RW-1:AW-1];
            assign ext_ovf = !((&hi) || (~|hi));
`ifdef ADDER_ACC_SATURATE_EN
            assign ext = !ext_ovf ? i_r[AW-1:0]
                       : (i_r[RW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}});
`else
            assign ext = i_r[AW-1:0];
`endif
        end
    endgenerate

    acc_sat_add #(.AW(AW)) u_add (
        .a   (acc),
        .b   (ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            acc     <= '0;
            cnt     <= '0;
            npass_q <= NW'(1);
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    // In HOLD a beat implies i_ready, so the result is consumed in the same cycle.
                    if (beat) begin
                        acc     <= ext;
                        cnt     <= NW'(1);
                        npass_q <= npass_eff;
                        state   <= (npass_eff == NW'(1)) ? ST_HOLD : ST_ACC;
                    end else if (state == ST_HOLD && i_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (beat) begin
                        acc <= add_sum;
                        cnt <= cnt_next;
                        if (cnt_next == npass_q) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADDER_ACC_SATURATE_EN
    logic sat_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sat_q <= 1'b0;
        end else if (beat) begin
            sat_q <= (state == ST_ACC) ? (sat_q | add_ovf) : ext_ovf;
        end
    end

    assign o_sat = sat_q;
`else
    logic unused_ovf;
    assign unused_ovf = add_ovf ^ ext_ovf;
    assign o_sat      = 1'b0;
`endif

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed table-driven bench for adder_tree_acc; expectations for the narrow
// overflow case follow the ADDER_ACC_SATURATE_EN macro.
module tb_adder_tree_acc;

    typedef struct {
        bit rst;
        bit valid;
        int r;
        int npass;
        bit ready;
        bit e_valid;
        int e_acc;
        bit e_ready;
    } vec_t;

    logic               clk;
    logic               rst;
    logic [7:0]         npass;
    logic               valid;
    logic signed [15:0] r;
    logic               ready_out;
    logic               valid_out;
    logic               ready_in;
    logic signed [23:0] acc_out;
    logic               sat_out;

    logic               s_rst;
    logic [7:0]         s_npass;
    logic               s_valid;
    logic signed [15:0] s_r;
    logic               s_ready_out;
    logic               s_valid_out;
    logic               s_ready_in;
    logic signed [15:0] s_acc_out;
    logic               s_sat_out;

    int   compared;
    int   mismatched;
    vec_t vecs[$];

    adder_tree_acc #(.RW(16), .AW(24), .NW(8)) dut (
        .CLK     (clk),
        .RST     (rst),
        .i_npass (npass),
        .i_valid (valid),
        .i_r     (r),
        .o_ready (ready_out),
        .o_valid (valid_out),
        .i_ready (ready_in),
        .o_acc   (acc_out),
        .o_sat   (sat_out)
    );

    adder_tree_acc #(.RW(16), .AW(16), .NW(8)) dut_narrow (
        .CLK     (clk),
        .RST     (s_rst),
        .i_npass (s_npass),
        .i_valid (s_valid),
        .i_r     (s_r),
        .o_ready (s_ready_out),
        .o_valid (s_valid_out),
        .i_ready (s_ready_in),
        .o_acc   (s_acc_out),
        .o_sat   (s_sat_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVector(input bit rs, input bit v, input int rv, input int np,
                             input bit rd, input bit ev, input int ea, input bit er);
        vec_t t;
        t.rst = rs; t.valid = v; t.r = rv; t.npass = np; t.ready = rd;
        t.e_valid = ev; t.e_acc = ea; t.e_ready = er;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t t);
        rst      = t.rst;
        valid    = t.valid;
        r        = 16'(t.r);
        npass    = 8'(t.npass);
        ready_in = t.ready;
    endtask

    task automatic checkOutput(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1; valid = 1'b0; r = '0; npass = 8'd1; ready_in = 1'b1;
        s_rst = 1'b1; s_valid = 1'b0; s_r = '0; s_npass = 8'd1; s_ready_in = 1'b1;

        //        rst v  r      np rdy  ev  e_acc  erdy
        addVector(1, 0, 0,     1, 1,   0,  0,     0);
        addVector(1, 1, 5,     1, 1,   0,  0,     0);
        // npass=4, -10..-40 -> -100 for exactly one cycle
        addVector(0, 1, -10,   4, 1,   0,  0,     1);
        addVector(0, 1, -20,   4, 1,   0,  -10,   1);
        addVector(0, 1, -30,   4, 1,   0,  -30,   1);
        addVector(0, 1, -40,   4, 1,   0,  -60,   1);
        addVector(0, 0, 0,     4, 1,   1,  -100,  1);
        addVector(0, 0, 0,     4, 1,   0,  -100,  1);
        // npass=1 streaming: one result per cycle
        addVector(0, 1, 5,     1, 1,   0,  -100,  1);
        addVector(0, 1, 7,     1, 1,   1,  5,     1);
        addVector(0, 1, 9,     1, 1,   1,  7,     1);
        addVector(0, 0, 0,     1, 1,   1,  9,     1);
        addVector(0, 0, 0,     1, 1,   0,  9,     1);
        // npass=2, result 3 held while the consumer stalls
        addVector(0, 1, 1,     2, 1,   0,  9,     1);
        addVector(0, 1, 2,     2, 1,   0,  1,     1);
        addVector(0, 1, 99,    2, 0,   1,  3,     0);
        addVector(0, 1, 99,    2, 0,   1,  3,     0);
        addVector(0, 1, 99,    2, 0,   1,  3,     0);
        addVector(0, 1, 99,    2, 1,   1,  3,     1);
        addVector(0, 1, 1,     5, 1,   0,  99,    1);
        addVector(0, 0, 0,     5, 1,   1,  100,   1);
        // reset mid-group, then 1+2+3+4
        addVector(0, 1, 100,   4, 1,   0,  100,   1);
        addVector(0, 1, 200,   4, 1,   0,  100,   1);
        addVector(1, 1, 50,    4, 1,   0,  300,   0);
        addVector(0, 1, 1,     4, 1,   0,  0,     1);
        addVector(0, 1, 2,     4, 1,   0,  1,     1);
        addVector(0, 1, 3,     4, 1,   0,  3,     1);
        addVector(0, 1, 4,     4, 1,   0,  6,     1);
        addVector(0, 0, 0,     4, 1,   1,  10,    1);
        // reset while a result is pending
        addVector(0, 1, -3,    1, 1,   0,  10,    1);
        addVector(1, 0, 0,     1, 0,   1,  -3,    0);
        addVector(0, 0, 0,     1, 1,   0,  0,     1);
        // npass=0 behaves as npass=1
        addVector(0, 1, -7,    0, 1,   0,  0,     1);
        addVector(0, 0, 0,     0, 1,   1,  -7,    1);
        addVector(0, 0, 0,     0, 1,   0,  -7,    1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d o_valid", i), int'(valid_out), int'(vecs[i].e_valid));
            checkOutput($sformatf("row%0d o_acc", i), int'(acc_out), vecs[i].e_acc);
            checkOutput($sformatf("row%0d o_ready", i), int'(ready_out), int'(vecs[i].e_ready));
            checkOutput($sformatf("row%0d o_sat", i), int'(sat_out), 0);
        end

        // AW=16: three beats of -20000 overflow the accumulator
        @(negedge clk);
        s_rst = 1'b0; s_valid = 1'b1; s_r = -16'sd20000; s_npass = 8'd3; s_ready_in = 1'b1;
        #1;
        checkOutput("narrow first o_ready", int'(s_ready_out), 1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        checkOutput("narrow o_valid", int'(s_valid_out), 1);
`ifdef ADDER_ACC_SATURATE_EN
        checkOutput("narrow o_acc", int'(s_acc_out), -32768);
        checkOutput("narrow o_sat", int'(s_sat_out), 1);
`else
        checkOutput("narrow o_acc", int'(s_acc_out), 5536);
        checkOutput("narrow o_sat", int'(s_sat_out), 0);
`endif
        // a new single-beat group clears the sticky flag
        @(negedge clk);
        s_valid = 1'b1; s_r = 16'sd1; s_npass = 8'd1;
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        checkOutput("narrow next o_valid", int'(s_valid_out), 1);
        checkOutput("narrow next o_acc", int'(s_acc_out), 1);
        checkOutput("narrow next o_sat", int'(s_sat_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
